// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and memory geometry.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES        = 4;
  localparam int unsigned MEM_BYTES_DEFAULT = 256;
  localparam int unsigned DATA_W            = 32;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last granted port.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  input  logic                     en,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] id
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    if (en) begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        idx = (32'(last) + k) % N_REQ;
        if (!found && req[idx[ID_W-1:0]]) begin
          found                 = 1'b1;
          grant[idx[ID_W-1:0]]  = 1'b1;
          id                    = idx[ID_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one big-endian word-wide data memory between N_REQ ports.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic [31:0]             mem_a,
  output logic [DATA_W-1:0]       mem_wd,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_rd
);

  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                bad_q, bad_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     gnt_id;
  logic [ADDR_W-1:0]   sel_addr;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req),
    .last  (last_q),
    .en    (state_q == ST_IDLE),
    .grant (grant),
    .id    (gnt_id)
  );

  assign sel_addr = addr[32'(gnt_id)*ADDR_W +: ADDR_W];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    bad_d   = bad_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          id_d    = gnt_id;
          last_d  = gnt_id;
          addr_d  = sel_addr;
          wdata_d = wdata[32'(gnt_id)*DATA_W +: DATA_W];
          we_d    = we[gnt_id];
          bad_d   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        err_d   = bad_q;
        rdata_d = (!we_q && !bad_q) ? mem_rd : '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Response is only meaningful alongside ack, so clear it on the way back to IDLE.
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ack     = '0;
    ack[id_q] = (state_q == ST_RESP);
  end

  assign err    = err_q;
  assign rdata  = rdata_q;
  assign busy   = (state_q != ST_IDLE);
  assign mem_a  = (state_q == ST_ACCESS && !bad_q) ? 32'(addr_q) : '0;
  assign mem_wd = (state_q == ST_ACCESS) ? wdata_q : '0;
  assign mem_we = (state_q == ST_ACCESS) && we_q && !bad_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural big-endian byte memory attached.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [7:0]  mem [0:255];
  logic [7:0]  a0;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.N_REQ(2), .ADDR_W(32), .MEM_BYTES(256)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .err    (err),
    .rdata  (rdata),
    .busy   (busy),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_we (mem_we),
    .mem_rd (mem_rd)
  );

  always #5 clk = ~clk;

  assign a0     = mem_a[7:0];
  assign mem_rd = {mem[a0], mem[a0 + 8'd1], mem[a0 + 8'd2], mem[a0 + 8'd3]};

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
      mem[8'h08] <= 8'h11;
      mem[8'h09] <= 8'h22;
      mem[8'h0A] <= 8'h33;
      mem[8'h0B] <= 8'h44;
    end else if (mem_we) begin
      mem[a0]         <= mem_wd[31:24];
      mem[a0 + 8'd1]  <= mem_wd[23:16];
      mem[a0 + 8'd2]  <= mem_wd[15:8];
      mem[a0 + 8'd3]  <= mem_wd[7:0];
    end
  end

  typedef struct {
    int          port;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int  we_cycles;
    int  lat;
    bit  got;
    we_cycles = 0;
    lat       = -1;
    got       = 0;
    we[p]            = w;
    addr[p*32 +: 32] = a;
    wdata[p*32 +: 32] = d;
    req[p]           = 1'b1;
    for (int c = 0; c < 8 && !got; c++) begin
      tick();
      if (mem_we) begin
        we_cycles++;
        chk({tag, " mem_a"}, mem_a, a);
        chk({tag, " mem_wd"}, mem_wd, d);
      end
      if (ack != 2'b00) begin
        got    = 1;
        lat    = c;
        req[p] = 1'b0;
        chk({tag, " ack"}, 32'(ack), 32'(2'b01 << p));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " rdata"}, rdata, exp_rd);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s ack_timeout: got no ack expected ack within 8 cycles", tag);
    end else begin
      chk({tag, " latency"}, 32'(lat), 32'd1);
    end
    chk({tag, " we_cycles"}, 32'(we_cycles), 32'(w && !exp_err));
    tick();
    chk({tag, " ack_drop"}, 32'(ack), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int          n_acks;
    bit          prev_ack;
    logic [1:0]  exp_ack;

    vecs[0]  = '{0, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h1122_3344};
    vecs[1]  = '{1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2]  = '{1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{0, 1'b0, 32'h0000_000A, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{0, 1'b1, 32'h0000_00FC, 32'h0102_0304, 1'b0, 32'h0};
    vecs[6]  = '{0, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h0102_0304};
    vecs[7]  = '{1, 1'b0, 32'h0000_00FD, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A4_A7A6};
    vecs[9]  = '{0, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[10] = '{1, 1'b0, 32'h0000_00F8, 32'h0,         1'b0, 32'h5D5C_5F5E};

    repeat (2) @(posedge clk);
    preload = 1'b0;
    #1;
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_a", mem_a, 32'd0);
    chk("rst mem_wd", mem_wd, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++)
      do_txn(vecs[i].port, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e_err, vecs[i].e_rd,
             $sformatf("v%0d", i));

    chk("mem 0x10", 32'(mem[8'h10]), 32'hDE);
    chk("mem 0x11", 32'(mem[8'h11]), 32'hAD);
    chk("mem 0x12", 32'(mem[8'h12]), 32'hBE);
    chk("mem 0x13", 32'(mem[8'h13]), 32'hEF);

    // Both ports hammer continuously; last grant was port 1, so port 0 leads.
    we    = 2'b00;
    addr  = {32'h0000_0010, 32'h0000_0008};
    req   = 2'b11;
    n_acks   = 0;
    prev_ack = 0;
    for (int c = 0; c < 40 && n_acks < 6; c++) begin
      tick();
      chk($sformatf("rr busy c%0d", c), 32'(busy), 32'(!prev_ack));
      if (ack != 2'b00) begin
        exp_ack = (n_acks % 2 == 0) ? 2'b01 : 2'b10;
        chk($sformatf("rr grant %0d", n_acks), 32'(ack), 32'(exp_ack));
        chk($sformatf("rr rdata %0d", n_acks), rdata,
            (exp_ack == 2'b01) ? 32'h1122_3344 : 32'hDEAD_BEEF);
        n_acks++;
        prev_ack = 1;
        if (n_acks == 6) req = 2'b00;
      end else begin
        prev_ack = 0;
      end
    end
    chk("rr n_acks", 32'(n_acks), 32'd6);
    tick();
    chk("rr idle ack", 32'(ack), 32'd0);
    chk("rr idle busy", 32'(busy), 32'd0);

    do_txn(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h1122_3344, "pre_rst");

    we    = 2'b01;
    addr  = {32'h0000_0008, 32'h0000_0020};
    wdata = {32'h0, 32'h55AA_55AA};
    req   = 2'b01;
    tick();
    chk("rst5 mem_we pre", 32'(mem_we), 32'd1);
    req = 2'b11;
    #1 rst_n = 1'b0;
    #1;
    chk("rst5 mem_we async", 32'(mem_we), 32'd0);
    chk("rst5 busy async", 32'(busy), 32'd0);
    chk("rst5 ack async", 32'(ack), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rst5 ack hold%0d", c), 32'(ack), 32'd0);
    end
    rst_n  = 1'b1;
    n_acks = 0;
    for (int c = 0; c < 20 && n_acks < 2; c++) begin
      tick();
      if (ack != 2'b00) begin
        if (n_acks == 0) begin
          chk("rst5 first grant", 32'(ack), 32'h1);
          chk("rst5 first err", 32'(err), 32'd0);
          req[0] = 1'b0;
        end else begin
          chk("rst5 second grant", 32'(ack), 32'h2);
          chk("rst5 second rdata", rdata, 32'h1122_3344);
          req[1] = 1'b0;
        end
        n_acks++;
      end
    end
    chk("rst5 n_acks", 32'(n_acks), 32'd2);
    tick();

    we    = 2'b00;
    addr  = {32'h0000_0010, 32'h0000_0008};
    req   = 2'b11;
    tick();
    chk("s6 p0 mem_a", mem_a, 32'h08);
    req[0]        = 1'b0;
    addr[63:32]   = 32'h0000_0000;
    tick();
    chk("s6 p0 ack", 32'(ack), 32'h1);
    chk("s6 p0 rdata", rdata, 32'h1122_3344);
    tick();
    chk("s6 idle busy", 32'(busy), 32'd0);
    chk("s6 idle ack", 32'(ack), 32'd0);
    tick();
    chk("s6 p1 mem_a", mem_a, 32'h0);
    chk("s6 p1 mem_we", 32'(mem_we), 32'd0);
    addr[63:32] = 32'h0000_0100;
    we[1]       = 1'b1;
    tick();
    chk("s6 p1 ack", 32'(ack), 32'h2);
    chk("s6 p1 err", 32'(err), 32'd0);
    chk("s6 p1 rdata", rdata, 32'hA5A4_A7A6);
    req = 2'b00;
    tick();
    chk("s6 end busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
